// File: rtl/fir_decim_tdm.sv
`default_nettype none
// =============================================================================
// Module   : fir_decim_tdm
// Brief    : Multi-channel decimating FIR with a tap-serial MAC shared in time,
//            all channels in parallel. Define FIR_SAT_EN for output clamping
//            and the sticky sat_flag; otherwise outputs wrap.
// Revision : 1.0 - initial release
// =============================================================================
module fir_decim_tdm #(
    parameter int TAP_COUNT  = 121,
    parameter int DECIM      = 8,
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 15
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           s_tvalid,
    output logic                           s_tready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_tdata,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [CHANNELS*OUT_WIDTH-1:0]  m_tdata,
    input  logic                           c_wr_en,
    input  logic [$clog2(TAP_COUNT)-1:0]   c_wr_addr,
    input  logic [COEF_WIDTH-1:0]          c_wr_data,
    output logic                           busy,
    output logic                           sat_flag
);

    localparam int c_addr_w = $clog2(TAP_COUNT);
    localparam int c_cnt_w  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int c_prod_w = DATA_WIDTH + COEF_WIDTH;
    localparam int c_acc_w  = c_prod_w + c_addr_w;

    localparam logic [c_addr_w-1:0]       c_last_tap = c_addr_w'(TAP_COUNT - 1);
    localparam logic [c_cnt_w-1:0]        c_last_dec = c_cnt_w'(DECIM - 1);
    localparam logic signed [c_acc_w-1:0] c_round    =
        (SHIFT > 0) ? (c_acc_w'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_MAC    = 2'd1,
        ST_ROUND  = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic                          r_run;
    logic [c_addr_w-1:0]           r_wr_ptr;
    logic [c_addr_w-1:0]           r_rd_ptr;
    logic [c_addr_w-1:0]           r_tap;
    logic [c_cnt_w-1:0]            r_dec_cnt;
    logic                          r_mvalid;
    logic                          w_accept;
    logic                          w_trigger;
    logic signed [COEF_WIDTH-1:0]  r_coef [TAP_COUNT];

    // r_run keeps s_tready low until the first edge after reset release
    assign w_accept  = (r_state == ST_ACCEPT) && r_run && s_tvalid;
    assign w_trigger = w_accept && (r_dec_cnt == c_last_dec);
    assign m_tvalid  = r_mvalid;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_ACCEPT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s_tready    = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_ACCEPT: begin
                s_tready = r_run;
                busy     = 1'b0;
                if (w_trigger) begin
                    w_state_nxt = ST_MAC;
                end
            end
            ST_MAC: begin
                if (r_tap == c_last_tap) begin
                    w_state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                w_state_nxt = ST_OUT;
            end
            default: begin
                if (m_tready) begin
                    w_state_nxt = ST_ACCEPT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_run     <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_tap     <= '0;
            r_dec_cnt <= '0;
            r_mvalid  <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                ST_ACCEPT: begin
                    if (w_accept) begin
                        // newest sample sits at the current write slot: tap 0
                        r_rd_ptr  <= r_wr_ptr;
                        r_wr_ptr  <= (r_wr_ptr == c_last_tap) ? '0 : r_wr_ptr + 1'b1;
                        r_dec_cnt <= (r_dec_cnt == c_last_dec) ? '0 : r_dec_cnt + 1'b1;
                        r_tap     <= '0;
                    end
                end
                ST_MAC: begin
                    r_tap    <= r_tap + 1'b1;
                    r_rd_ptr <= (r_rd_ptr == '0) ? c_last_tap : r_rd_ptr - 1'b1;
                end
                ST_ROUND: begin
                    r_mvalid <= 1'b1;
                end
                default: begin
                    if (m_tready) begin
                        r_mvalid <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Coefficients deliberately survive reset
    always_ff @(posedge clk) begin
        if (c_wr_en && !busy && (c_wr_addr <= c_last_tap)) begin
            r_coef[c_wr_addr] <= c_wr_data;
        end
    end

`ifdef FIR_SAT_EN
    localparam logic signed [OUT_WIDTH-1:0] c_out_max = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] c_out_min = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    logic [CHANNELS-1:0] w_ovf;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [DATA_WIDTH-1:0] r_dline [TAP_COUNT];
        logic signed [c_acc_w-1:0]    r_acc;
        logic signed [OUT_WIDTH-1:0]  r_out;
        logic signed [c_prod_w-1:0]   w_prod;
        logic signed [c_acc_w-1:0]    w_sum;
        logic signed [OUT_WIDTH-1:0]  w_y_out;

        assign w_prod = c_prod_w'(r_dline[r_rd_ptr]) * c_prod_w'(r_coef[r_tap]);
        assign w_sum  = r_acc + c_round;
`ifdef FIR_SAT_EN
        logic signed [c_acc_w-1:0]  w_y;
        logic [c_acc_w-OUT_WIDTH:0] w_hi;
        assign w_y      = w_sum >>> SHIFT;
        assign w_hi     = w_y[c_acc_w-1:OUT_WIDTH-1];
        assign w_ovf[c] = !((&w_hi) || !(|w_hi));
        assign w_y_out  = w_ovf[c] ? (w_y[c_acc_w-1] ? c_out_min : c_out_max)
                                   : w_y[OUT_WIDTH-1:0];
`else
        assign w_y_out  = OUT_WIDTH'(w_sum >>> SHIFT);
`endif

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                for (int i = 0; i < TAP_COUNT; i++) begin
                    r_dline[i] <= '0;
                end
                r_acc <= '0;
                r_out <= '0;
            end else begin
                if (w_accept) begin
                    r_dline[r_wr_ptr] <= s_tdata[c*DATA_WIDTH +: DATA_WIDTH];
                end
                if (w_trigger) begin
                    r_acc <= '0;
                end else if (r_state == ST_MAC) begin
                    r_acc <= r_acc + c_acc_w'(w_prod);
                end
                if (r_state == ST_ROUND) begin
                    r_out <= w_y_out;
                end
            end
        end

        assign m_tdata[c*OUT_WIDTH +: OUT_WIDTH] = r_out;
    end

`ifdef FIR_SAT_EN
    logic r_sat;
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sat <= 1'b0;
        end else if ((r_state == ST_ROUND) && (|w_ovf)) begin
            r_sat <= 1'b1;
        end
    end
    assign sat_flag = r_sat;
`else
    assign sat_flag = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_tdm.sv
`default_nettype none
// =============================================================================
// Module   : tb_fir_decim_tdm
// Brief    : Directed self-checking bench for fir_decim_tdm (default params).
// Revision : 1.0 - initial release
// =============================================================================
module tb_fir_decim_tdm;

    localparam int TAPS = 121;
    localparam int DEC  = 8;
    localparam int DW   = 16;
    localparam int OW   = 16;
    localparam int AW   = $clog2(TAPS);

`ifdef FIR_SAT_EN
    localparam logic [OW-1:0] SAT_Y    = 16'h7FFF;
    localparam logic          SAT_FLAG = 1'b1;
`else
    localparam logic [OW-1:0] SAT_Y    = 16'h7F0E;
    localparam logic          SAT_FLAG = 1'b0;
`endif

    logic            clk      = 1'b0;
    logic            nrst     = 1'b1;
    logic            s_tvalid = 1'b0;
    logic            s_tready;
    logic [2*DW-1:0] s_tdata  = '0;
    logic            m_tvalid;
    logic            m_tready = 1'b1;
    logic [2*OW-1:0] m_tdata;
    logic            c_wr_en   = 1'b0;
    logic [AW-1:0]   c_wr_addr = '0;
    logic [15:0]     c_wr_data = '0;
    logic            busy;
    logic            sat_flag;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int beat_no  = 0;
    int mode     = 0;

    fir_decim_tdm dut (
        .clk       (clk),
        .nrst      (nrst),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .c_wr_en   (c_wr_en),
        .c_wr_addr (c_wr_addr),
        .c_wr_data (c_wr_data),
        .busy      (busy),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // mode 0: impulse on ch0 beat 0; 1: DC 0x0100; 2: full scale; 3: impulse on ch0 beat 2
    function automatic logic [DW-1:0] gen(input int ch, input int b);
        case (mode)
            0:       return (ch == 0 && b == 0) ? 16'h4000 : 16'h0000;
            1:       return 16'h0100;
            2:       return 16'h7FFF;
            3:       return (ch == 0 && b == 2) ? 16'h4000 : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic pulse_reset();
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        c_wr_en  = 1'b0;
        nrst     = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        beat_no = 0;
    endtask

    task automatic load_coefs(input logic [15:0] val, input bit ramp);
        for (int k = 0; k < TAPS; k++) begin
            c_wr_en   = 1'b1;
            c_wr_addr = AW'(k);
            c_wr_data = ramp ? 16'(k) : val;
            @(negedge clk);
        end
        c_wr_en = 1'b0;
    endtask

    task automatic send_frame(output int t_acc);
        for (int i = 0; i < DEC; i++) begin
            int guard;
            guard    = 0;
            s_tdata  = {gen(1, beat_no), gen(0, beat_no)};
            s_tvalid = 1'b1;
            while (!s_tready && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            if (!s_tready) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_timeout: beat %0d never accepted", beat_no);
            end
            @(negedge clk);
            beat_no++;
        end
        s_tvalid = 1'b0;
        t_acc    = cyc;
    endtask

    task automatic get_output(input int t_acc, input int stall,
                              output logic [OW-1:0] y0, output logic [OW-1:0] y1);
        int            guard;
        int            n_bad;
        logic [2*OW-1:0] held;
        guard = 0;
        n_bad = 0;
        if (stall > 0) m_tready = 1'b0;
        while (!m_tvalid && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (!m_tvalid) begin
            n_fail++;
            $display("FAIL out_timeout: m_tvalid=0 after %0d cycles, required 1", guard);
            y0 = 16'hDEAD;
            y1 = 16'hDEAD;
            m_tready = 1'b1;
            return;
        end
        n_checks++;
        if (cyc - t_acc !== TAPS + 1) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, required %0d", cyc - t_acc, TAPS + 1);
        end
        held = m_tdata;
        y0   = held[OW-1:0];
        y1   = held[2*OW-1:OW];
        for (int i = 0; i < stall; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = {gen(1, beat_no), gen(0, beat_no)};
            @(negedge clk);
            if (m_tvalid !== 1'b1 || m_tdata !== held || s_tready !== 1'b0 || busy !== 1'b1)
                n_bad++;
        end
        if (stall > 0) begin
            n_checks++;
            if (n_bad != 0) begin
                n_fail++;
                $display("FAIL stall_hold: got %0d unstable cycles, required 0", n_bad);
            end
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL consume: m_tvalid=%0b s_tready=%0b, required 0/1", m_tvalid, s_tready);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_s_tready: got %0b required 0", s_tready); end
        n_checks++;
        if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_tvalid: got %0b required 0", m_tvalid); end
        n_checks++;
        if (m_tdata !== '0) begin n_fail++; $display("FAIL rst_m_tdata: got %h required 0", m_tdata); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b required 0", busy); end
        n_checks++;
        if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL rst_sat_flag: got %0b required 0", sat_flag); end
        nrst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_tready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %0b required 1", s_tready); end
        beat_no = 0;
    endtask

    task automatic test_impulse(input bit load);
        int t;
        logic [OW-1:0] y0, y1;
        if (load) load_coefs(16'h0, 1'b1);
        mode = 0;
        for (int j = 0; j < 17; j++) begin
            send_frame(t);
            get_output(t, 0, y0, y1);
            n_checks++;
            if (y0 !== 16'((j < 15) ? 4 * j + 4 : 0)) begin
                n_fail++;
                $display("FAIL impulse_ch0[%0d]: got %0d required %0d", j, y0, (j < 15) ? 4 * j + 4 : 0);
            end
            n_checks++;
            if (y1 !== 16'h0) begin n_fail++; $display("FAIL impulse_ch1[%0d]: got %0d required 0", j, y1); end
        end
    endtask

    task automatic test_reset_mid_mac();
        int t;
        pulse_reset();
        mode = 0;
        send_frame(t);
        repeat (49) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midmac_busy: got %0b required 1", busy); end
        nrst = 1'b0;
        #1;
        n_checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midmac_abort: m_tvalid=%0b s_tready=%0b busy=%0b required 0/0/0", m_tvalid, s_tready, busy);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL midmac_held: m_tvalid=%0b s_tready=%0b required 0/0", m_tvalid, s_tready);
        end
        nrst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_tready !== 1'b1) begin n_fail++; $display("FAIL midmac_release: got %0b required 1", s_tready); end
        beat_no = 0;
        test_impulse(1'b0);
    endtask

    task automatic test_backpressure();
        int t;
        logic [OW-1:0] y0, y1;
        pulse_reset();
        mode = 0;
        for (int j = 0; j < 6; j++) begin
            send_frame(t);
            get_output(t, (j == 2) ? 300 : 0, y0, y1);
            n_checks++;
            if (y0 !== 16'(4 * j + 4) || y1 !== 16'h0) begin
                n_fail++;
                $display("FAIL bp_out[%0d]: got %0d/%0d required %0d/0", j, y0, y1, 4 * j + 4);
            end
        end
    endtask

    task automatic test_coef_write_busy();
        int t;
        logic [OW-1:0] y0, y1;
        pulse_reset();
        mode = 3;
        send_frame(t);
        c_wr_en   = 1'b1;
        c_wr_addr = AW'(5);
        c_wr_data = 16'h1234;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL cw_busy: got %0b required 1", busy); end
        @(negedge clk);
        c_wr_en = 1'b0;
        get_output(t, 0, y0, y1);
        n_checks++;
        if (y0 !== 16'd3 || y1 !== 16'd0) begin
            n_fail++;
            $display("FAIL cw_ignored: got %0d/%0d required 3/0", y0, y1);
        end
        c_wr_en   = 1'b1;
        c_wr_addr = AW'(5);
        c_wr_data = 16'h1234;
        @(negedge clk);
        c_wr_en = 1'b0;
        pulse_reset();
        mode = 3;
        send_frame(t);
        get_output(t, 0, y0, y1);
        n_checks++;
        if (y0 !== 16'd2330 || y1 !== 16'd0) begin
            n_fail++;
            $display("FAIL cw_applied: got %0d/%0d required 2330/0", y0, y1);
        end
    endtask

    task automatic test_dc();
        int t;
        logic [OW-1:0] y0, y1;
        pulse_reset();
        load_coefs(16'h0100, 1'b0);
        mode = 1;
        for (int j = 0; j < 17; j++) begin
            send_frame(t);
            get_output(t, 0, y0, y1);
            n_checks++;
            if (y0 !== 16'((j < 15) ? 16 * j + 16 : 242) || y1 !== 16'((j < 15) ? 16 * j + 16 : 242)) begin
                n_fail++;
                $display("FAIL dc[%0d]: got %0d/%0d required %0d", j, y0, y1, (j < 15) ? 16 * j + 16 : 242);
            end
        end
    endtask

    task automatic test_saturation();
        int t;
        logic [OW-1:0] y0, y1;
        pulse_reset();
        load_coefs(16'h7FFF, 1'b0);
        mode = 2;
        for (int j = 0; j < 17; j++) begin
            send_frame(t);
            get_output(t, 0, y0, y1);
            if (j >= 15) begin
                n_checks++;
                if (y0 !== SAT_Y || y1 !== SAT_Y) begin
                    n_fail++;
                    $display("FAIL sat_out[%0d]: got %h/%h required %h", j, y0, y1, SAT_Y);
                end
                n_checks++;
                if (sat_flag !== SAT_FLAG) begin
                    n_fail++;
                    $display("FAIL sat_flag[%0d]: got %0b required %0b", j, sat_flag, SAT_FLAG);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse(1'b1);
        test_reset_mid_mac();
        test_backpressure();
        test_coef_write_busy();
        test_dc();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
